serial_seq_det: RTL

- Bit-serial pattern detector that sits directly downstream of the d_ff stage and consumes its registered q output as a 1-bit data stream.
- Shifts in one bit per qualified clock and compares the last PAT_LEN bits against a fixed PATTERN.
- Emits a one-cycle match pulse and keeps a saturating count of matches.
- Feeds the status/LED logic of the flip-flop exercise.

---
 rtl/serial_seq_det.sv | 96 +++++++++
 1 files changed

// File: rtl/serial_seq_det.sv
// rtl/serial_seq_det.sv - bit-serial PATTERN detector with saturating match counter
// Define SEQ_DET_OVERLAP_EN to keep history after a match so overlapping occurrences are detected.
module serial_seq_det #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic [4:0]       fill_lvl
);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FILLING,
      ST_ARMED
   } state_t;

   logic [PAT_LEN-1:0] shift_q, shift_d, shift_nx;
   logic [4:0]         fill_q, fill_d, fill_nx;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               match_q, match_d;
   logic               hit;
   state_t             state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         shift_q <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         match_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
      end
   end

   // fill level is the FSM state; the enum names its three regions
   always_comb begin
      state = ST_FILLING;
      if (fill_q == 5'd0)
         state = ST_EMPTY;
      else if (fill_q == 5'(PAT_LEN))
         state = ST_ARMED;
   end

   always_comb begin
      shift_d  = shift_q;
      fill_d   = fill_q;
      cnt_d    = cnt_q;
      match_d  = 1'b0;
      shift_nx = {shift_q[PAT_LEN-2:0], din};
      fill_nx  = fill_q;
      hit      = 1'b0;

      case (state)
         ST_EMPTY, ST_FILLING: fill_nx = fill_q + 5'd1;
         default:              fill_nx = fill_q;
      endcase

      if (clr) begin
         shift_d = '0;
         fill_d  = '0;
         cnt_d   = '0;
      end else if (din_valid) begin
         // compare on next-state values so the pulse follows the completing edge
         hit     = (fill_nx == 5'(PAT_LEN)) && (shift_nx == PATTERN);
         shift_d = shift_nx;
         fill_d  = fill_nx;
         if (hit) begin
            match_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}})
               cnt_d = cnt_q + 1'b1;
`ifdef SEQ_DET_OVERLAP_EN
            shift_d = shift_nx;
            fill_d  = fill_nx;
`else
            shift_d = '0;
            fill_d  = '0;
`endif
         end
      end
   end

   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign fill_lvl  = fill_q;

endmodule
